// File: rtl/uart_rx_16x.sv
// UART byte receiver oversampling rxd on a 1-clk sample_en strobe; start bit validated at mid-bit,
// data sampled at bit centres LSB first. Define UART_RX_PARITY_EN to add a parity bit and live rx_parity_err.
module uart_rx_16x #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BRK_WAIT
  } state_t;
`endif

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic                 rxd_s;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 tick_end;

  assign rxd_s    = sync2_q;
  assign tick_end = sample_en && (tick_q == TICK_END);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic; everything advances only on sample_en.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (sample_en && !rxd_s) state_d = S_START;
      S_START:
        if (sample_en && (tick_q == TICK_MID)) state_d = rxd_s ? S_IDLE : S_DATA;
      S_DATA:
        if (tick_end && (bit_q == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      S_PARITY:
        if (tick_end) state_d = S_STOP;
`endif
      S_STOP:
        // Sampling mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (tick_end) state_d = rxd_s ? S_IDLE : S_BRK_WAIT;
      S_BRK_WAIT:
        if (sample_en && rxd_s) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Datapath and output strobes.
  always_comb begin
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    if (sample_en) begin
      unique case (state_q)
        S_IDLE, S_BRK_WAIT: begin
          tick_d = '0;
          bit_d  = '0;
        end
        S_START: begin
          tick_d = (tick_q == TICK_MID) ? '0 : tick_q + TW'(1);
          bit_d  = '0;
        end
        S_DATA: begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BW'(1);
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY:
          tick_d = (tick_q == TICK_END) ? '0 : tick_q + TW'(1);
`endif
        S_STOP: begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            valid_d = 1'b1;
            data_d  = shift_q;
            ferr_d  = ~rxd_s;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: tick_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_flag_q, par_flag_d;
  logic perr_q, perr_d;

  // Parity flag is latched mid parity bit and published with the stop-bit sample.
  always_comb begin
    par_flag_d = par_flag_q;
    perr_d     = perr_q;
    if (tick_end && (state_q == S_PARITY)) par_flag_d = rxd_s ^ (^shift_q) ^ PAR_ODD;
    if (tick_end && (state_q == S_STOP))   perr_d     = par_flag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_flag_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      par_flag_q <= par_flag_d;
      perr_q     <= perr_d;
    end
  end

  assign rx_parity_err = perr_q;
`else
  // Parity polarity has no effect without a parity bit; the AND keeps the output constant 0.
  assign rx_parity_err = 1'b0 & PAR_ODD;
`endif

  // Output logic.
  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = (state_q != S_IDLE);

endmodule
